// File: rtl/fmsubsample_pkg.sv
// ---------------------------------------------------------------------------
// fmsubsample_pkg
//
// Shared definitions for the feature-map crop/subsample stage:
//   - cfg_addr_e   : geometry register map addressed by wa
//   - stream_bits  : byte-aligned tdata width for a given beat payload
//   - fold_bits    : fold counter width (at least one bit)
//
// The per-dimension geometry struct is declared inside the top module, where
// the counter widths are known.
// ---------------------------------------------------------------------------
package fmsubsample_pkg;

  localparam int CFG_ADDR_BITS = 3;
  localparam int CFG_DATA_BITS = 32;

  // Geometry register map. X occupies 0..3 and Y 4..7 with the same layout.
  typedef enum logic [CFG_ADDR_BITS-1:0] {
    X_START  = 3'd0,
    X_STOP   = 3'd1,  // inclusive
    X_END    = 3'd2,  // input width - 1
    X_STRIDE = 3'd3,
    Y_START  = 3'd4,
    Y_STOP   = 3'd5,
    Y_END    = 3'd6,
    Y_STRIDE = 3'd7
  } cfg_addr_e;

  // tdata width: SIMD elements rounded up to whole bytes.
  function automatic int stream_bits(input int simd, input int elem_bits);
    return 8 * (1 + (simd * elem_bits - 1) / 8);
  endfunction

  // A single-beat pixel still gets a one-bit fold counter that never moves.
  function automatic int fold_bits(input int folds);
    return (folds > 1) ? $clog2(folds) : 1;
  endfunction

endpackage

// File: rtl/fmsubsample_dim_ctr.sv
// ---------------------------------------------------------------------------
// fmsubsample_dim_ctr
//
// One spatial dimension (column or row) of the crop/subsample window.
// Tracks the pixel position and the stride phase, and reports whether the
// current position is kept and whether it is the last position of the line.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   advance     move to the next position (one pulse per pixel / per line)
//   cfg_start   first kept position
//   cfg_stop    last kept position (inclusive)
//   cfg_last    last position of the dimension (size - 1)
//   cfg_stride  keep every cfg_stride-th position from cfg_start; 0 acts as 1
//   wrap        current position is cfg_last (the next advance wraps to 0)
//   keep        current position lies in the window and on the stride grid
//
// wrap and keep are decoded from registered state only, so the keep decision
// for a beat never depends on the beat's own data or handshake.
// ---------------------------------------------------------------------------
module fmsubsample_dim_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic [W-1:0] cfg_start,
  input  logic [W-1:0] cfg_stop,
  input  logic [W-1:0] cfg_last,
  input  logic [W-1:0] cfg_stride,
  output logic         wrap,
  output logic         keep
);

  logic [W-1:0] pos;
  logic [W-1:0] ph;
  logic [W-1:0] pos_next;
  logic [W-1:0] ph_next;
  logic [W-1:0] ph_last;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here each one is assigned unconditionally or on both branches), so no
  // latch can be inferred.
  always_comb begin
    ph_last  = (cfg_stride == '0) ? '0 : cfg_stride - W'(1);
    wrap     = (pos == cfg_last);
    pos_next = wrap ? '0 : pos + W'(1);

    // The phase re-anchors whenever the next position is the window start,
    // so every line (and every image) begins its stride grid at cfg_start.
    if (pos_next == cfg_start) begin
      ph_next = '0;
    end else if (ph == ph_last) begin
      ph_next = '0;
    end else begin
      ph_next = ph + W'(1);
    end

    keep = (pos >= cfg_start) && (pos <= cfg_stop) && (ph == '0);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
      ph  <= '0;
    end else if (advance) begin
      pos <= pos_next;
      ph  <= ph_next;
    end
  end

endmodule

// File: rtl/fmsubsample_axi.sv
// ---------------------------------------------------------------------------
// fmsubsample_axi
//
// Crop/subsample stage for an AXI-Stream pixel stream. Each pixel arrives as
// NUM_CHANNELS/SIMD beats; pixels inside the configured X/Y window and on the
// configured X/Y stride grid are forwarded unchanged, all other beats are
// accepted and discarded.
//
// Ports:
//   ap_clk, ap_rst   clock, asynchronous active-high reset
//   we, wa, wd       geometry register write (see cfg_addr_e); wd is
//                    truncated to the target field width
//   s_axis_*         input stream (tready, tvalid, tdata)
//   m_axis_*         output stream, driven from a single output register
//
// Geometry registers are written before or during reset (or at an image
// boundary); changing them mid-image gives undefined output.
// ---------------------------------------------------------------------------
module fmsubsample_axi
  import fmsubsample_pkg::*;
#(
  parameter int XCOUNTER_BITS = 8,
  parameter int YCOUNTER_BITS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int SIMD          = 2,
  parameter int ELEM_BITS     = 4,
  parameter int STREAM_BITS   = stream_bits(SIMD, ELEM_BITS)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,

  input  logic                     we,
  input  logic [CFG_ADDR_BITS-1:0] wa,
  input  logic [CFG_DATA_BITS-1:0] wd,

  output logic                     s_axis_tready,
  input  logic                     s_axis_tvalid,
  input  logic [STREAM_BITS-1:0]   s_axis_tdata,

  input  logic                     m_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [STREAM_BITS-1:0]   m_axis_tdata
);

  localparam int FOLDS     = NUM_CHANNELS / SIMD;
  localparam int FOLD_BITS = fold_bits(FOLDS);
  localparam logic [FOLD_BITS-1:0] FOLD_LAST = FOLD_BITS'(FOLDS - 1);

  // Per-dimension geometry; 'last' holds the End field (size - 1).
  typedef struct packed {
    logic [XCOUNTER_BITS-1:0] start;
    logic [XCOUNTER_BITS-1:0] stop;
    logic [XCOUNTER_BITS-1:0] last;
    logic [XCOUNTER_BITS-1:0] stride;
  } x_cfg_t;

  typedef struct packed {
    logic [YCOUNTER_BITS-1:0] start;
    logic [YCOUNTER_BITS-1:0] stop;
    logic [YCOUNTER_BITS-1:0] last;
    logic [YCOUNTER_BITS-1:0] stride;
  } y_cfg_t;

  x_cfg_t cfg_x;
  y_cfg_t cfg_y;

  logic [FOLD_BITS-1:0] fold;
  logic                 fold_last;
  logic                 s_fire;
  logic                 out_free;
  logic                 keep;
  logic                 x_keep;
  logic                 y_keep;
  logic                 x_wrap;
  logic                 x_advance;
  logic                 y_advance;
  logic                 unused_y_wrap;
  logic                 unused_wd;

  // Upper wd bits are deliberately discarded by truncation.
  assign unused_wd = ^wd;

  // -------------------------------------------------------------------------
  // Geometry registers
  // -------------------------------------------------------------------------
  // NOTE: the geometry registers are plain configuration storage with no
  // reset: they must survive ap_rst, and software may load them while reset
  // is held.
  always_ff @(posedge ap_clk) begin
    if (we) begin
      case (cfg_addr_e'(wa))
        X_START:  cfg_x.start  <= wd[XCOUNTER_BITS-1:0];
        X_STOP:   cfg_x.stop   <= wd[XCOUNTER_BITS-1:0];
        X_END:    cfg_x.last   <= wd[XCOUNTER_BITS-1:0];
        X_STRIDE: cfg_x.stride <= wd[XCOUNTER_BITS-1:0];
        Y_START:  cfg_y.start  <= wd[YCOUNTER_BITS-1:0];
        Y_STOP:   cfg_y.stop   <= wd[YCOUNTER_BITS-1:0];
        Y_END:    cfg_y.last   <= wd[YCOUNTER_BITS-1:0];
        Y_STRIDE: cfg_y.stride <= wd[YCOUNTER_BITS-1:0];
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Fold counter: beats within one pixel
  // -------------------------------------------------------------------------
  assign fold_last = (fold == FOLD_LAST);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      fold <= '0;
    end else if (s_fire) begin
      fold <= fold_last ? '0 : fold + FOLD_BITS'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Column and row position / phase tracking
  // -------------------------------------------------------------------------
  // Columns step once per pixel (after its last beat); rows step when the
  // column counter wraps.
  assign x_advance = s_fire && fold_last;
  assign y_advance = x_advance && x_wrap;

  fmsubsample_dim_ctr #(
    .W (XCOUNTER_BITS)
  ) u_x_ctr (
    .clk        (ap_clk),
    .rst        (ap_rst),
    .advance    (x_advance),
    .cfg_start  (cfg_x.start),
    .cfg_stop   (cfg_x.stop),
    .cfg_last   (cfg_x.last),
    .cfg_stride (cfg_x.stride),
    .wrap       (x_wrap),
    .keep       (x_keep)
  );

  fmsubsample_dim_ctr #(
    .W (YCOUNTER_BITS)
  ) u_y_ctr (
    .clk        (ap_clk),
    .rst        (ap_rst),
    .advance    (y_advance),
    .cfg_start  (cfg_y.start),
    .cfg_stop   (cfg_y.stop),
    .cfg_last   (cfg_y.last),
    .cfg_stride (cfg_y.stride),
    .wrap       (unused_y_wrap),
    .keep       (y_keep)
  );

  // -------------------------------------------------------------------------
  // Input handshake and output register
  // -------------------------------------------------------------------------
  // keep is decoded from counter state, so the whole pixel's beats share one
  // decision. Dropped beats are always accepted; kept beats wait only for the
  // output register to be empty or draining this cycle.
  assign keep          = x_keep && y_keep;
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = keep ? out_free : 1'b1;
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (s_fire && keep) begin
      // Also covers drain-and-reload in the same cycle.
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmsubsample_axi.sv
// ---------------------------------------------------------------------------
// tb_fmsubsample_axi
//
// Directed bench for fmsubsample_axi with the default geometry widths
// (SIMD=2, NUM_CHANNELS=4, 8-bit tdata) on a 10x7 image, i.e. 140 beats per
// image with input beat i carrying i modulo 256.
// ---------------------------------------------------------------------------
module tb_fmsubsample_axi;

  localparam int SB          = 8;
  localparam int IMG_W       = 10;
  localparam int IMG_H       = 7;
  localparam int FOLDS       = 2;
  localparam int IMG_BEATS   = IMG_W * IMG_H * FOLDS;
  localparam int WAIT_LIMIT  = 1000;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          we;
  logic [2:0]    wa;
  logic [31:0]   wd;
  logic          s_axis_tready;
  logic          s_axis_tvalid;
  logic [SB-1:0] s_axis_tdata;
  logic          m_axis_tready;
  logic          m_axis_tvalid;
  logic [SB-1:0] m_axis_tdata;

  int            n_cmp  = 0;
  int            n_fail = 0;
  bit            rdy_random = 1'b0;
  logic [7:0]    obs[$];
  logic [7:0]    exp_q[$];

  always #5 ap_clk = ~ap_clk;

  fmsubsample_axi dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .we            (we),
    .wa            (wa),
    .wd            (wd),
    .s_axis_tready (s_axis_tready),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata)
  );

  // Output capture: inputs change only just after a rising edge, so the
  // falling edge sees exactly the handshake that completes on the next edge.
  always @(negedge ap_clk) begin
    if (m_axis_tvalid && m_axis_tready) obs.push_back(m_axis_tdata);
  end

  // Random output backpressure when enabled.
  initial forever begin
    @(posedge ap_clk);
    #1;
    if (rdy_random) m_axis_tready = ($urandom_range(0, 2) != 0);
  end

  // Global time limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic write_cfg(input logic [2:0] addr, input int data);
    we = 1'b1;
    wa = addr;
    wd = data;
    tick();
    we = 1'b0;
  endtask

  task automatic set_cfg(input int xs, input int xp, input int xe, input int xstr,
                         input int ys, input int yp, input int ye, input int ystr);
    write_cfg(3'd0, xs);
    write_cfg(3'd1, xp);
    write_cfg(3'd2, xe);
    write_cfg(3'd3, xstr);
    write_cfg(3'd4, ys);
    write_cfg(3'd5, yp);
    write_cfg(3'd6, ye);
    write_cfg(3'd7, ystr);
  endtask

  // Present one beat for one cycle; acc reports whether it was taken.
  task automatic offer(input logic [7:0] data, output bit acc);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    @(negedge ap_clk);
    acc = s_axis_tready;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  // Send n beats numbered first.. (mod 256); cycles counts offered cycles.
  task automatic send_beats(input int first, input int n, input bit gaps,
                            output int cycles);
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      bit acc;
      int waited;
      acc    = 1'b0;
      waited = 0;
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      while (!acc) begin
        if (waited == WAIT_LIMIT) begin
          n_cmp++;
          n_fail++;
          $error("FAIL send_timeout: beat %0d not accepted after %0d cycles", first + i, waited);
          return;
        end
        offer(8'((first + i) & 255), acc);
        cycles++;
        waited++;
      end
    end
  endtask

  task automatic drain();
    repeat (30) tick();
    rdy_random    = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
  endtask

  // Reference beat list: a pixel is kept when it lies in the window and its
  // offset from the window start is a multiple of the stride.
  task automatic build_exp(input int xs, input int xp, input int xstr,
                           input int ys, input int yp, input int ystr,
                           input int images);
    exp_q.delete();
    for (int img = 0; img < images; img++)
      for (int y = 0; y < IMG_H; y++)
        for (int x = 0; x < IMG_W; x++)
          if (x >= xs && x <= xp && (x - xs) % xstr == 0 &&
              y >= ys && y <= yp && (y - ys) % ystr == 0)
            for (int f = 0; f < FOLDS; f++)
              exp_q.push_back(8'((img * IMG_BEATS + (y * IMG_W + x) * FOLDS + f) & 255));
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check($sformatf("%s_count", tag), obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), obs[i], exp_q[i]);
  endtask

  initial begin
    bit acc;
    int cycles;

    ap_rst        = 1'b1;
    we            = 1'b0;
    wa            = '0;
    wd            = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    repeat (2) tick();

    // Reset state; identity geometry loaded while reset is held.
    set_cfg(0, 9, 9, 1, 0, 6, 6, 1);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tdata", m_axis_tdata, 8'h00);
    check("rst_s_tready", s_axis_tready, 1'b1);
    ap_rst = 1'b0;
    tick();

    // Identity: every beat passes, one cycle latency, full rate.
    obs.delete();
    offer(8'h00, acc);
    check("first_acc", acc, 1'b1);
    check("lat_m_tvalid", m_axis_tvalid, 1'b1);
    check("lat_m_tdata", m_axis_tdata, 8'h00);
    send_beats(1, IMG_BEATS - 1, 1'b0, cycles);
    check("identity_cycles", cycles, IMG_BEATS - 1);
    drain();
    build_exp(0, 9, 1, 0, 6, 1, 1);
    compare_stream("identity");

    // Crop + stride, two back-to-back images.
    ap_rst = 1'b1;
    set_cfg(1, 8, 9, 2, 0, 6, 6, 3);
    ap_rst = 1'b0;
    tick();
    obs.delete();
    send_beats(0, 2 * IMG_BEATS, 1'b0, cycles);
    drain();
    check("crop_total", obs.size(), 48);
    check("crop_o0", obs[0], 8'h02);
    check("crop_o1", obs[1], 8'h03);
    check("crop_o2", obs[2], 8'h06);
    check("crop_o3", obs[3], 8'h07);
    check("crop_row3_a", obs[8], 8'h3E);
    check("crop_row3_b", obs[9], 8'h3F);
    check("crop_img2_first", obs[24], 8'h8E);
    build_exp(1, 8, 2, 0, 6, 3, 2);
    compare_stream("crop");

    // Backpressure: same geometry, config not rewritten.
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    tick();
    obs.delete();
    for (int i = 0; i < 4; i++) offer(8'(i), acc);
    check("bp_beat3_acc", acc, 1'b1);
    m_axis_tready = 1'b0;
    offer(8'h04, acc);
    check("bp_drop4_while_stalled", acc, 1'b1);
    offer(8'h05, acc);
    check("bp_drop5_while_stalled", acc, 1'b1);
    for (int i = 0; i < 8; i++) offer(8'h06, acc);
    check("bp_kept6_blocked", acc, 1'b0);
    check("bp_hold_tvalid", m_axis_tvalid, 1'b1);
    check("bp_hold_tdata", m_axis_tdata, 8'h03);
    rdy_random = 1'b1;
    send_beats(6, 2 * IMG_BEATS - 6, 1'b1, cycles);
    drain();
    build_exp(1, 8, 2, 0, 6, 3, 2);
    compare_stream("backpressure");

    // X stride 0 behaves as stride 1.
    ap_rst = 1'b1;
    set_cfg(1, 8, 9, 0, 0, 6, 6, 1);
    ap_rst = 1'b0;
    tick();
    obs.delete();
    send_beats(0, IMG_BEATS, 1'b0, cycles);
    drain();
    build_exp(1, 8, 1, 0, 6, 1, 1);
    compare_stream("stride0");

    // Reset after 37 beats: beat 36 (pixel x=8,y=1) is held in the output.
    send_beats(0, 37, 1'b0, cycles);
    check("midrst_pre_tvalid", m_axis_tvalid, 1'b1);
    ap_rst = 1'b1;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_tdata", m_axis_tdata, 8'h00);
    tick();
    ap_rst = 1'b0;
    tick();
    obs.delete();
    send_beats(0, IMG_BEATS, 1'b0, cycles);
    drain();
    build_exp(1, 8, 1, 0, 6, 1, 1);
    compare_stream("after_reset");

    // Single-pixel window at the bottom-right corner, two images.
    ap_rst = 1'b1;
    set_cfg(9, 9, 9, 1, 6, 6, 6, 1);
    ap_rst = 1'b0;
    tick();
    obs.delete();
    send_beats(0, 2 * IMG_BEATS, 1'b0, cycles);
    drain();
    exp_q = '{8'h8A, 8'h8B, 8'h16, 8'h17};
    compare_stream("single_pixel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
